// File: rtl/nonce_result_collector_if.sv
// Bundles the miner result stream and the host-side read/status signals
// of nonce_result_collector. The miner/host side uses master; the collector uses slave.
interface nonce_result_collector_if #(
    parameter int NONCEBITS  = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int SEQBITS    = 4
);
    // Miner result stream
    logic                  valid_i;
    logic                  newblock_i;
    logic                  success_i;
    // Host reader side
    logic                  rd_ack;
    logic                  clr_ovf;
    logic                  rd_valid;
    logic [NONCEBITS-1:0]  rd_nonce;
    logic [SEQBITS-1:0]    rd_seq;
    logic [DEPTH_LOG2:0]   fill;
    logic                  overflow;

    modport master (
        output valid_i, newblock_i, success_i, rd_ack, clr_ovf,
        input  rd_valid, rd_nonce, rd_seq, fill, overflow
    );

    modport slave (
        input  valid_i, newblock_i, success_i, rd_ack, clr_ovf,
        output rd_valid, rd_nonce, rd_seq, fill, overflow
    );
endinterface

// File: rtl/nonce_result_collector.sv
// Rebuilds nonces from the miner result stream, tags winners with a block sequence
// number and queues them in a show-ahead FIFO; a new block flushes stale winners.
module nonce_result_collector #(
    parameter int NONCEBITS   = 32,
    parameter int DEPTH_LOG2  = 3,
    parameter int SEQBITS     = 4,
    parameter int NONCE_START = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    nonce_result_collector_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [NONCEBITS-1:0]  START      = NONCEBITS'(NONCE_START);
    localparam logic [NONCEBITS-1:0]  START_NEXT = NONCEBITS'(NONCE_START + 1);
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_MINING = 1'b1;

    logic [0:0]            state;
    logic [NONCEBITS-1:0]  counter;
    logic [SEQBITS-1:0]    seq;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow_q;

    logic [NONCEBITS-1:0]  mem_nonce [DEPTH];
    logic [SEQBITS-1:0]    mem_seq   [DEPTH];

    logic                  new_block;
    logic                  accept;
    logic                  push_req;
    logic                  empty;
    logic                  full_eff;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [NONCEBITS-1:0]  nonce_cur;
    logic [SEQBITS-1:0]    seq_eff;

    // A new block restarts the nonce sequence and empties the queue before
    // its own result is considered, so it can never be dropped or pop an entry.
    assign new_block = bus.valid_i & bus.newblock_i;
    assign accept    = bus.valid_i & (bus.newblock_i | (state == S_MINING));
    assign push_req  = accept & bus.success_i;
    assign nonce_cur = new_block ? START : counter;
    assign seq_eff   = new_block ? seq + 1'b1 : seq;
    assign empty     = (count == '0);
    assign full_eff  = ~new_block & (count == FULL_COUNT);
    assign pop       = bus.rd_ack & ~empty & ~new_block;
    assign push      = push_req & (~full_eff | pop);
    assign drop      = push_req & full_eff & ~pop;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            counter    <= START;
            seq        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (new_block) begin
                state   <= S_MINING;
                counter <= START_NEXT;
                seq     <= seq_eff;
            end else if (accept) begin
                counter <= counter + 1'b1;
            end

            if (new_block) begin
                rd_ptr <= wr_ptr;
                wr_ptr <= wr_ptr + DEPTH_LOG2'(push);
                count  <= (DEPTH_LOG2+1)'(push);
            end else begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(pop);
                wr_ptr <= wr_ptr + DEPTH_LOG2'(push);
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            if (drop)
                overflow_q <= 1'b1;
            else if (bus.clr_ovf)
                overflow_q <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count and the
    // outputs are masked while empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_nonce[wr_ptr] <= nonce_cur;
            mem_seq[wr_ptr]   <= seq_eff;
        end
    end

    assign bus.rd_valid = ~empty;
    assign bus.rd_nonce = empty ? '0 : mem_nonce[rd_ptr];
    assign bus.rd_seq   = empty ? '0 : mem_seq[rd_ptr];
    assign bus.fill     = count;
    assign bus.overflow = overflow_q;

endmodule
